// File: rtl/cordic_vectoring.sv
// -----------------------------------------------------------------------------
// cordic_vectoring
//
// Iterative CORDIC in vectoring mode. It converts a Q4.8 cartesian vector
// (x, y) into polar form. The magnitude is scaled by the CORDIC gain
// K ~= 1.647 and saturated to [0, 2047]. The angle is atan2(y, x) in Q4.8
// radians. The block works on one vector at a time and carries an ID tag
// through to the result.
//
// Ports:
//   clock      system clock
//   reset      synchronous, active-high reset
//   in_valid   input vector valid
//   in_ready   block can accept a vector (high only while idle)
//   in_x/in_y  signed Q4.8 input vector
//   in_id      tag that travels with the vector
//   out_valid  result valid (held until out_ready)
//   out_ready  consumer accepts the result
//   out_mag    Q4.8 magnitude * K, saturated, never negative
//   out_angle  signed Q4.8 angle, roughly [-804, +804]
//   out_id     tag of the result
//
// Timing: a vector accepted at edge N gives out_valid high after edge
// N+STAGES. The block returns to idle one cycle after the result is taken,
// so the throughput is one vector every STAGES+2 cycles.
// -----------------------------------------------------------------------------
module cordic_vectoring #(
    parameter int ID_WIDTH = 8,
    parameter int STAGES   = 10,   // 1..10, bounded by the atan table
    parameter int IW       = 14    // internal x/y/z width, >= 13
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [11:0]         in_x,
    input  logic [11:0]         in_y,
    input  logic [ID_WIDTH-1:0] in_id,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [11:0]         out_mag,
    output logic [11:0]         out_angle,
    output logic [ID_WIDTH-1:0] out_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic signed [IW-1:0] PI_2    = IW'(402);
    localparam logic signed [IW-1:0] MAG_MAX = IW'(2047);
    localparam logic [3:0]           LAST    = 4'(STAGES - 1);

    // atan(2^-i) in Q4.8 radians
    function automatic logic signed [IW-1:0] atan_lut(input logic [3:0] idx);
        logic signed [IW-1:0] v;
        case (idx)
            4'd0:    v = IW'(201);
            4'd1:    v = IW'(119);
            4'd2:    v = IW'(63);
            4'd3:    v = IW'(32);
            4'd4:    v = IW'(16);
            4'd5:    v = IW'(8);
            4'd6:    v = IW'(4);
            4'd7:    v = IW'(2);
            4'd8:    v = IW'(1);
            4'd9:    v = IW'(1);
            default: v = '0;
        endcase
        return v;
    endfunction

    state_t                state_reg;
    logic [3:0]            iter_reg;
    logic signed [IW-1:0]  x_reg;
    logic signed [IW-1:0]  y_reg;
    logic signed [IW-1:0]  z_reg;
    logic [ID_WIDTH-1:0]   id_reg;

    // ---------------------------------------------------------------------
    // Input sign extension and quadrant pre-rotation. The negation is done
    // at IW width, so -2048 negates cleanly to +2048.
    // ---------------------------------------------------------------------
    logic signed [IW-1:0] x_ext;
    logic signed [IW-1:0] y_ext;
    logic signed [IW-1:0] x0_next;
    logic signed [IW-1:0] y0_next;
    logic signed [IW-1:0] z0_next;

    assign x_ext = {{(IW-12){in_x[11]}}, in_x};
    assign y_ext = {{(IW-12){in_y[11]}}, in_y};

    always_comb begin
        x0_next = x_ext;
        y0_next = y_ext;
        z0_next = '0;
        if (x_ext[IW-1]) begin
            if (!y_ext[IW-1]) begin
                // Second quadrant: rotate by -90 degrees, angle starts at +pi/2
                x0_next = y_ext;
                y0_next = -x_ext;
                z0_next = PI_2;
            end else begin
                // Third quadrant: rotate by +90 degrees, angle starts at -pi/2
                x0_next = -y_ext;
                y0_next = x_ext;
                z0_next = -PI_2;
            end
        end
    end

    // ---------------------------------------------------------------------
    // One micro-rotation on the current registers. Both the x and y updates
    // use the values from before this step.
    // ---------------------------------------------------------------------
    logic signed [IW-1:0] x_sh;
    logic signed [IW-1:0] y_sh;
    logic signed [IW-1:0] atan_i;
    logic signed [IW-1:0] x_next;
    logic signed [IW-1:0] y_next;
    logic signed [IW-1:0] z_next;
    logic [11:0]          mag_sat;

    assign x_sh   = x_reg >>> iter_reg;
    assign y_sh   = y_reg >>> iter_reg;
    assign atan_i = atan_lut(iter_reg);

    always_comb begin
        if (!y_reg[IW-1]) begin
            x_next = x_reg + y_sh;
            y_next = y_reg - x_sh;
            z_next = z_reg + atan_i;
        end else begin
            x_next = x_reg - y_sh;
            y_next = y_reg + x_sh;
            z_next = z_reg - atan_i;
        end
    end

    // x cannot go negative after pre-rotation. The lower clamp is kept so
    // the output is still well defined if that ever changes.
    always_comb begin
        if (x_next[IW-1]) begin
            mag_sat = 12'd0;
        end else if (x_next > MAG_MAX) begin
            mag_sat = 12'd2047;
        end else begin
            mag_sat = x_next[11:0];
        end
    end

    // ---------------------------------------------------------------------
    // Control FSM and registered outputs
    // ---------------------------------------------------------------------
    assign in_ready = (state_reg == IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            iter_reg  <= '0;
            x_reg     <= '0;
            y_reg     <= '0;
            z_reg     <= '0;
            id_reg    <= '0;
            out_valid <= 1'b0;
            out_mag   <= '0;
            out_angle <= '0;
            out_id    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        x_reg     <= x0_next;
                        y_reg     <= y0_next;
                        z_reg     <= z0_next;
                        id_reg    <= in_id;
                        iter_reg  <= '0;
                        state_reg <= ITER;
                    end
                end
                ITER: begin
                    x_reg <= x_next;
                    y_reg <= y_next;
                    z_reg <= z_next;
                    if (iter_reg == LAST) begin
                        out_mag   <= mag_sat;
                        out_angle <= z_next[11:0];
                        out_id    <= id_reg;
                        out_valid <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        iter_reg <= iter_reg + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_vectoring.sv
// -----------------------------------------------------------------------------
// tb_cordic_vectoring
//
// Testbench for cordic_vectoring. It applies table-driven vectors with
// approximate polar expectations, then runs hand-written sequences for
// backpressure and for a reset in the middle of an operation. After that it
// sends 1000 random vectors with random gaps. Every result is compared
// bit-exactly against an integer reference model of the vectoring algorithm,
// and IDs are tracked in a queue of pending requests.
// -----------------------------------------------------------------------------
module tb_cordic_vectoring;

    localparam int STAGES = 10;

    logic        clock     = 1'b0;
    logic        reset     = 1'b1;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [11:0] in_x      = '0;
    logic [11:0] in_y      = '0;
    logic [7:0]  in_id     = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] out_mag;
    logic [11:0] out_angle;
    logic [7:0]  out_id;

    cordic_vectoring #(
        .ID_WIDTH (8),
        .STAGES   (STAGES),
        .IW       (14)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_id     (in_id),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mag   (out_mag),
        .out_angle (out_angle),
        .out_id    (out_id)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    int atan_tab [10] = '{201, 119, 63, 32, 16, 8, 4, 2, 1, 1};

    typedef struct {
        int x;
        int y;
        int id;
    } pend_t;
    pend_t pend_q[$];

    typedef struct {
        int x;
        int y;
        int id;
        int ang;
        int ang_tol;
        int mag;
        int mag_tol;
    } vec_t;
    vec_t tab [8];

    // Reference: polar conversion by repeated micro-rotations on plain
    // integers, starting from the quadrant-corrected vector.
    function automatic void model(input int x, input int y, output int mag, output int ang);
        int cx, cy, z, t;
        if (x >= 0) begin
            cx = x;  cy = y;  z = 0;
        end else if (y >= 0) begin
            cx = y;  cy = -x; z = 402;
        end else begin
            cx = -y; cy = x;  z = -402;
        end
        for (int i = 0; i < STAGES; i++) begin
            t = cx;
            if (cy >= 0) begin
                cx = cx + (cy >>> i);
                cy = cy - (t >>> i);
                z  = z + atan_tab[i];
            end else begin
                cx = cx - (cy >>> i);
                cy = cy + (t >>> i);
                z  = z - atan_tab[i];
            end
        end
        mag = (cx < 0) ? 0 : ((cx > 2047) ? 2047 : cx);
        ang = z;
    endfunction

    task automatic chk(input string name, input int act, input int exp, input int tol);
        vectors++;
        if (act < exp - tol || act > exp + tol) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    // Called on a negative edge. Returns on the negative edge right after
    // the accepting rising edge.
    task automatic send(input int x, input int y, input int id);
        int n;
        pend_t p;
        n = 0;
        in_x     = 12'(x);
        in_y     = 12'(y);
        in_id    = 8'(id);
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("send_ready", int'(in_ready), 1, 0);
        p.x = x; p.y = y; p.id = id;
        pend_q.push_back(p);
        @(negedge clock);
        in_valid = 1'b0;
        chk("in_ready_drop", int'(in_ready), 0, 0);
    endtask

    task automatic drive_junk(input bit junk);
        if (junk) begin
            in_valid = 1'($urandom_range(0, 1));
            in_x     = 12'($urandom);
            in_y     = 12'($urandom);
            in_id    = 8'hEE;
        end
    endtask

    // Waits for the result, stalls for `hold` cycles, checks it against the
    // oldest pending request, then releases it.
    task automatic recv(input int hold, input bit junk, output int mag_o, output int ang_o);
        int n, m, a;
        pend_t p;
        n = 0;
        out_ready = 1'b0;
        while (!out_valid && n < 50) begin
            drive_junk(junk);
            @(negedge clock);
            n++;
        end
        chk("out_valid_seen", int'(out_valid), 1, 0);
        chk("latency", n, STAGES, 0);
        for (int h = 0; h < hold; h++) begin
            drive_junk(junk);
            @(negedge clock);
        end
        in_valid = 1'b0;
        chk("pending_count", pend_q.size(), 1, 0);
        mag_o = int'(out_mag);
        ang_o = int'($signed(out_angle));
        if (pend_q.size() > 0) begin
            p = pend_q.pop_front();
            model(p.x, p.y, m, a);
            chk("mag", mag_o, m, 0);
            chk("angle", ang_o, a, 0);
            chk("id", int'(out_id), p.id, 0);
        end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        chk("out_valid_drop", int'(out_valid), 0, 0);
    endtask

    initial begin
        int m, a, m0, a0, id0, cnt, x, y;
        pend_t p;

        tab[0] = '{256,    0,    8'h11,   -1, 0,  424, 0};
        tab[1] = '{0,      256,  8'h21,  402, 3,  421, 4};
        tab[2] = '{-256,   0,    8'h22,  804, 3,  421, 4};
        tab[3] = '{-256,  -256,  8'h23, -603, 3,  596, 6};
        tab[4] = '{0,     -256,  8'h24, -402, 3,  421, 4};
        tab[5] = '{2047,   2047, 8'h31,  201, 3, 2047, 0};
        tab[6] = '{-2048, -2048, 8'h32, -603, 3, 2047, 0};
        tab[7] = '{0,      0,    8'h40,    0, 0,    0, 0};

        // Reset state
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk("rst_out_valid", int'(out_valid), 0, 0);
        chk("rst_in_ready", int'(in_ready), 1, 0);
        chk("rst_out_mag", int'(out_mag), 0, 0);
        chk("rst_out_angle", int'(out_angle), 0, 0);
        chk("rst_out_id", int'(out_id), 0, 0);

        // Table-driven vectors. The (0,0) entry is checked only bit-exactly
        // inside recv; its approximate bounds are the model's own values.
        for (int k = 0; k < 8; k++) begin
            send(tab[k].x, tab[k].y, tab[k].id);
            recv(0, 1'b0, m, a);
            if (k < 7) begin
                chk($sformatf("tab%0d_mag", k), m, tab[k].mag, tab[k].mag_tol);
                chk($sformatf("tab%0d_angle", k), a, tab[k].ang, tab[k].ang_tol);
            end
        end

        // Backpressure: the result stays stable and new input is ignored.
        send(100, -50, 8'h55);
        cnt = 0;
        while (!out_valid && cnt < 50) begin
            @(negedge clock);
            cnt++;
        end
        chk("bp_valid", int'(out_valid), 1, 0);
        m0  = int'(out_mag);
        a0  = int'($signed(out_angle));
        id0 = int'(out_id);
        p = pend_q.pop_front();
        model(p.x, p.y, m, a);
        chk("bp_mag", m0, m, 0);
        chk("bp_angle", a0, a, 0);
        chk("bp_id", id0, 8'h55, 0);
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'b1;
            in_x     = 12'($urandom);
            in_y     = 12'($urandom);
            in_id    = 8'hEE;
            @(negedge clock);
            chk("bp_hold_valid", int'(out_valid), 1, 0);
            chk("bp_hold_ready", int'(in_ready), 0, 0);
            chk("bp_hold_mag", int'(out_mag), m0, 0);
            chk("bp_hold_angle", int'($signed(out_angle)), a0, 0);
            chk("bp_hold_id", int'(out_id), id0, 0);
        end
        in_x      = 12'(300);
        in_y      = 12'(-20);
        in_id     = 8'h66;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        chk("bp_rel_valid", int'(out_valid), 0, 0);
        chk("bp_rel_ready", int'(in_ready), 1, 0);
        p.x = 300; p.y = -20; p.id = 8'h66;
        pend_q.push_back(p);
        @(negedge clock);
        in_valid = 1'b0;
        chk("bp_accept", int'(in_ready), 0, 0);
        recv(0, 1'b0, m, a);

        // Reset in the middle of the iterations aborts the operation.
        send(500, 300, 8'h77);
        pend_q.delete();
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort_valid", int'(out_valid), 0, 0);
        chk("abort_ready", int'(in_ready), 1, 0);
        cnt = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clock);
            if (out_valid) cnt++;
        end
        chk("abort_no_result", cnt, 0, 0);
        send(128, 128, 8'h78);
        recv(1, 1'b0, m, a);
        chk("post_abort_angle", a, 201, 3);
        chk("post_abort_mag", m, 298, 4);

        // Random vectors with random input gaps and output stalls
        for (int v = 0; v < 1000; v++) begin
            repeat ($urandom_range(0, 3)) @(negedge clock);
            if ($urandom_range(0, 3) == 0) begin
                x = int'($urandom_range(0, 64)) - 32;
                y = int'($urandom_range(0, 64)) - 32;
            end else begin
                x = int'($urandom_range(0, 4095)) - 2048;
                y = int'($urandom_range(0, 4095)) - 2048;
            end
            send(x, y, v & 255);
            recv(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), m, a);
        end

        // No stray results once the traffic stops
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (out_valid) cnt++;
        end
        chk("no_extra_result", cnt, 0, 0);
        chk("queue_empty", pend_q.size(), 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
